dmem_arbiter: RTL and testbench

- Shares the single data-memory port (RAM plus led/BCD MMIO at 0x4000000C/0x40000010) between the pipeline MEM stage (CPU) and one auxiliary word requester (DMA: loader/debug port).
- CPU has priority. DMA gets single-cycle slots when the CPU is idle, or forcibly after a bounded starvation window, with the CPU stalled for that slot.
- Sits between the MEM stage, the DMA source and the data memory. The memory's combinational read and clocked write timing are unchanged.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage (priority) and one
// auxiliary word requester; the DMA side is forced through after a starvation window.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_mem_read,
  input  logic             cpu_mem_write,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic [31:0]      dma_addr,
  input  logic [31:0]      dma_wdata,
  input  logic             dma_we,
  output logic             dma_ack,
  output logic [31:0]      dma_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] dma_count
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_CPU,
    S_DMA,
    S_ACK
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  starve_cnt;
  logic [31:0] dma_addr_q;
  logic [31:0] dma_wdata_q;
  logic        dma_we_q;
  logic        cpu_active;
  logic        grant;

  assign cpu_active = cpu_mem_read | cpu_mem_write;
  assign grant      = (state == S_CPU) && dma_req && (!cpu_active || starve_cnt == LIMIT);

  always_comb begin
    state_next = state;
    case (state)
      S_CPU:   if (grant) state_next = S_DMA;
      S_DMA:   state_next = S_ACK;
      S_ACK:   state_next = S_CPU;
      default: state_next = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CPU;
    end else begin
      state <= state_next;
    end
  end

  // Starvation counter only advances while the DMA is actually being blocked by CPU traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant) begin
      starve_cnt <= '0;
    end else if (state == S_CPU && dma_req && cpu_active && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_addr_q  <= '0;
      dma_wdata_q <= '0;
      dma_we_q    <= 1'b0;
    end else if (grant) begin
      dma_addr_q  <= {dma_addr[31:2], 2'b00};
      dma_wdata_q <= dma_wdata;
      dma_we_q    <= dma_we;
    end
  end

  // Ack and counter update together at the end of the DMA slot so they are seen in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
      dma_count <= '0;
    end else begin
      dma_ack <= (state == S_DMA);
      if (state == S_DMA) begin
        dma_count <= dma_count + CNT_W'(1);
        if (!dma_we_q) begin
          dma_rdata <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    if (state == S_DMA) begin
      mem_addr  = dma_addr_q;
      mem_wdata = dma_wdata_q;
      mem_read  = !dma_we_q;
      mem_write = dma_we_q;
      cpu_rdata = '0;
      cpu_stall = cpu_active;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a small RAM + led/BCD memory model,
// plus hand-written reset sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_mem_read, cpu_mem_write, cpu_stall;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [15:0] dma_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:1023];
  logic [31:0] led_reg, bcd_reg;

  typedef struct {
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_a;
    logic [31:0] cpu_wd;
    logic        req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic        e_stall;
    logic        e_ack;
    logic        e_mrd;
    logic        e_mwr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_crdata;
    logic [31:0] e_drdata;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs [0:26];

  dmem_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_mem_read  (cpu_mem_read),
    .cpu_mem_write (cpu_mem_write),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dma_req       (dma_req),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_we        (dma_we),
    .dma_ack       (dma_ack),
    .dma_rdata     (dma_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_rdata     (mem_rdata),
    .dma_count     (dma_count)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, two MMIO words.
  always_comb begin
    if (mem_addr == 32'h4000000C)      mem_rdata = led_reg;
    else if (mem_addr == 32'h40000010) mem_rdata = bcd_reg;
    else                               mem_rdata = ram[mem_addr[11:2]];
  end

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_addr == 32'h4000000C)      led_reg <= mem_wdata;
      else if (mem_addr == 32'h40000010) bcd_reg <= mem_wdata;
      else                               ram[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_mem_read  = v.cpu_rd;
    cpu_mem_write = v.cpu_wr;
    cpu_addr      = v.cpu_a;
    cpu_wdata     = v.cpu_wd;
    dma_req       = v.req;
    dma_addr      = v.d_addr;
    dma_wdata     = v.d_wdata;
    dma_we        = v.d_we;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    compare($sformatf("v%0d cpu_stall", idx), {31'b0, cpu_stall}, {31'b0, v.e_stall});
    compare($sformatf("v%0d dma_ack", idx), {31'b0, dma_ack}, {31'b0, v.e_ack});
    compare($sformatf("v%0d mem_read", idx), {31'b0, mem_read}, {31'b0, v.e_mrd});
    compare($sformatf("v%0d mem_write", idx), {31'b0, mem_write}, {31'b0, v.e_mwr});
    compare($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
    compare($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_mwdata);
    compare($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.e_crdata);
    compare($sformatf("v%0d dma_rdata", idx), dma_rdata, v.e_drdata);
    compare($sformatf("v%0d dma_count", idx), {16'b0, dma_count}, {16'b0, v.e_count});
  endtask

  initial begin
    int waited;

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[1]  = 32'h62;
    ram[2]  = 32'h11;
    led_reg = 32'h0;
    bcd_reg = 32'h0;

    // cpu_rd cpu_wr cpu_a cpu_wd | req d_addr d_wdata d_we | stall ack mrd mwr maddr mwdata crdata drdata count
    // Idle CPU, DMA read of word 1.
    vecs[0]  = '{0,0,32'h0,32'h0, 1,32'h4,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h0,16'd0};
    vecs[1]  = '{0,0,32'h0,32'h0, 1,32'h4,32'h0,0, 0,0,1,0,32'h4,32'h0,32'h0,32'h0,16'd0};
    vecs[2]  = '{0,0,32'h0,32'h0, 1,32'h4,32'h0,0, 0,1,0,0,32'h0,32'h0,32'h0,32'h62,16'd1};
    vecs[3]  = '{0,0,32'h0,32'h0, 0,32'h0,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h62,16'd1};
    // CPU lw every cycle, DMA write forced through after the starvation window.
    for (int i = 4; i <= 8; i++)
      vecs[i] = '{1,0,32'h8,32'h0, 1,32'h400,32'h55,1, 0,0,1,0,32'h8,32'h0,32'h11,32'h62,16'd1};
    vecs[9]  = '{1,0,32'h8,32'h0, 1,32'h400,32'h55,1, 1,0,0,1,32'h400,32'h55,32'h0,32'h62,16'd1};
    vecs[10] = '{1,0,32'h8,32'h0, 1,32'h400,32'h55,1, 0,1,1,0,32'h8,32'h0,32'h11,32'h62,16'd2};
    vecs[11] = '{1,0,32'h8,32'h0, 0,32'h0,32'h0,0, 0,0,1,0,32'h8,32'h0,32'h11,32'h62,16'd2};
    // DMA write to BCD MMIO.
    vecs[12] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h1234,1, 0,0,0,0,32'h0,32'h0,32'h0,32'h62,16'd2};
    vecs[13] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h1234,1, 0,0,0,1,32'h40000010,32'h1234,32'h0,32'h62,16'd2};
    vecs[14] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h1234,1, 0,1,0,0,32'h0,32'h0,32'h0,32'h62,16'd3};
    vecs[15] = '{0,0,32'h0,32'h0, 0,32'h0,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h62,16'd3};
    // DMA read back of BCD; req held through ack and into S_CPU gives exactly one more access.
    vecs[16] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h62,16'd3};
    vecs[17] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,0,1,0,32'h40000010,32'h0,32'h0,32'h62,16'd3};
    vecs[18] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,1,0,0,32'h0,32'h0,32'h0,32'h1234,16'd4};
    vecs[19] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h1234,16'd4};
    vecs[20] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,0,1,0,32'h40000010,32'h0,32'h0,32'h1234,16'd4};
    vecs[21] = '{0,0,32'h0,32'h0, 1,32'h40000010,32'h0,0, 0,1,0,0,32'h0,32'h0,32'h0,32'h1234,16'd5};
    vecs[22] = '{0,0,32'h0,32'h0, 0,32'h0,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h1234,16'd5};
    // Unaligned DMA address is word-aligned on the port.
    vecs[23] = '{0,0,32'h0,32'h0, 1,32'h7,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h1234,16'd5};
    vecs[24] = '{0,0,32'h0,32'h0, 1,32'h7,32'h0,0, 0,0,1,0,32'h4,32'h0,32'h0,32'h1234,16'd5};
    vecs[25] = '{0,0,32'h0,32'h0, 1,32'h7,32'h0,0, 0,1,0,0,32'h0,32'h0,32'h0,32'h62,16'd6};
    // CPU store to the led MMIO passes straight through.
    vecs[26] = '{0,1,32'h4000000C,32'hA5, 0,32'h0,32'h0,0, 0,0,0,1,32'h4000000C,32'hA5,32'h0,32'h62,16'd6};

    reset = 1'b0;
    applyStimulus('{0,0,32'h0,32'h0, 0,32'h0,32'h0,0, 0,0,0,0,32'h0,32'h0,32'h0,32'h0,16'd0});
    repeat (2) @(posedge clk);
    #1;
    compare("reset dma_ack", {31'b0, dma_ack}, 32'h0);
    compare("reset cpu_stall", {31'b0, cpu_stall}, 32'h0);
    compare("reset dma_count", {16'b0, dma_count}, 32'h0);
    compare("reset dma_rdata", dma_rdata, 32'h0);
    reset = 1'b1;

    @(posedge clk);
    #1;
    for (int i = 0; i <= 26; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end
    cpu_mem_write = 1'b0;
    compare("ram[0x400] written by DMA", ram[256], 32'h55);
    compare("led written by CPU", led_reg, 32'hA5);

    // Reset pulse while the DMA owns the port drops the access without an ack.
    dma_req  = 1'b1;
    dma_addr = 32'hC;
    dma_we   = 1'b0;
    @(posedge clk);
    #1;
    compare("pre-reset S_DMA mem_read", {31'b0, mem_read}, 32'h1);
    compare("pre-reset S_DMA mem_addr", mem_addr, 32'hC);
    reset   = 1'b0;
    dma_req = 1'b0;
    #1;
    compare("mid-reset mem_read", {31'b0, mem_read}, 32'h0);
    compare("mid-reset dma_ack", {31'b0, dma_ack}, 32'h0);
    compare("mid-reset dma_count", {16'b0, dma_count}, 32'h0);
    compare("mid-reset dma_rdata", dma_rdata, 32'h0);
    @(posedge clk);
    #1;
    compare("held-reset dma_ack", {31'b0, dma_ack}, 32'h0);
    reset = 1'b1;

    // New request after release completes normally with the usual latency.
    dma_req  = 1'b1;
    dma_addr = 32'h8;
    dma_we   = 1'b0;
    waited   = 0;
    while (waited < 10 && dma_ack !== 1'b1) begin
      @(posedge clk);
      #1;
      waited++;
    end
    compare("post-reset ack latency", 32'(waited), 32'd2);
    compare("post-reset dma_ack", {31'b0, dma_ack}, 32'h1);
    compare("post-reset dma_rdata", dma_rdata, 32'h11);
    compare("post-reset dma_count", {16'b0, dma_count}, 32'h1);
    dma_req = 1'b0;
    @(posedge clk);
    #1;
    compare("post-reset ack one cycle", {31'b0, dma_ack}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
